// File: rtl/as_ethernet_header_writer_32bit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : as_ethernet_header_writer_32bit_pkg                             |
// | Brief   : shared state encodings and ctrl codes for the header writer    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package as_ethernet_header_writer_32bit_pkg;

  typedef enum logic [3:0] {
    WORD_1   = 4'b0001,
    WORD_2   = 4'b0010,
    WORD_3   = 4'b0100,
    WAIT_EOP = 4'b1000
  } state_t;

  localparam int CTRL_DATA    = 0;
  localparam int CTRL_MOD_HDR = 2;

endpackage
`default_nettype wire

// File: rtl/as_ethernet_header_writer_32bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : as_ethernet_header_writer_32bit                                 |
// | Brief   : overwrites dst/src MAC of each packet with lookup-supplied     |
// |           values; registered output, one cycle latency                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module as_ethernet_header_writer_32bit
  import as_ethernet_header_writer_32bit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [47:0]           hdr_dst_mac,
  input  logic [47:0]           hdr_src_mac,
  input  logic                  hdr_rewrite_en,
  input  logic                  hdr_vld,
  output logic                  hdr_rd,
  output logic [31:0]           num_rewritten,
  output logic [31:0]           num_bypassed
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_dst_mac_lo;
  logic [47:0]           r_src_mac;
  logic                  r_rewrite_en;
  logic                  w_accept;
  logic                  w_is_data;
  logic [DATA_WIDTH-1:0] w_out_data;

  // Module-header words also wait for hdr_vld in WORD_1; keeps ready a single term.
  assign in_rdy    = out_rdy & ~((r_state == WORD_1) & ~hdr_vld);
  assign w_accept  = in_wr & in_rdy;
  assign w_is_data = (in_ctrl == CTRL_WIDTH'(CTRL_DATA));

  always_comb begin
    w_state_nxt = r_state;
    w_out_data  = in_data;
    hdr_rd      = 1'b0;
    case (r_state)
      WORD_1: begin
        if (w_accept && w_is_data) begin
          hdr_rd      = 1'b1;
          w_state_nxt = WORD_2;
          if (hdr_rewrite_en) w_out_data = hdr_dst_mac[47:16];
        end
      end
      WORD_2: begin
        if (w_accept) begin
          w_state_nxt = w_is_data ? WORD_3 : WORD_1;
          if (r_rewrite_en) w_out_data = {r_dst_mac_lo, r_src_mac[47:32]};
        end
      end
      WORD_3: begin
        if (w_accept) begin
          w_state_nxt = w_is_data ? WAIT_EOP : WORD_1;
          if (r_rewrite_en) w_out_data = r_src_mac[31:0];
        end
      end
      WAIT_EOP: begin
        if (w_accept && !w_is_data) w_state_nxt = WORD_1;
      end
      default: w_state_nxt = WORD_1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= WORD_1;
      r_dst_mac_lo  <= '0;
      r_src_mac     <= '0;
      r_rewrite_en  <= 1'b0;
      out_data      <= '0;
      out_ctrl      <= '0;
      out_wr        <= 1'b0;
      num_rewritten <= '0;
      num_bypassed  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      out_data <= w_out_data;
      out_ctrl <= in_ctrl;
      out_wr   <= w_accept;
      if (hdr_rd) begin
        r_dst_mac_lo <= hdr_dst_mac[15:0];
        r_src_mac    <= hdr_src_mac;
        r_rewrite_en <= hdr_rewrite_en;
        if (hdr_rewrite_en) num_rewritten <= num_rewritten + 32'd1;
        else                num_bypassed  <= num_bypassed + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_as_ethernet_header_writer_32bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_as_ethernet_header_writer_32bit                              |
// | Brief   : scoreboard bench with a packet-level reference model           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_as_ethernet_header_writer_32bit;
  import as_ethernet_header_writer_32bit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [31:0] out_data;
  logic [3:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic [47:0] hdr_dst_mac = '0;
  logic [47:0] hdr_src_mac = '0;
  logic        hdr_rewrite_en = 1'b0;
  logic        hdr_vld = 1'b0;
  logic        hdr_rd;
  logic [31:0] num_rewritten;
  logic [31:0] num_bypassed;

  always #5 clk = ~clk;

  as_ethernet_header_writer_32bit #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_rewrite_en(hdr_rewrite_en), .hdr_vld(hdr_vld), .hdr_rd(hdr_rd),
    .num_rewritten(num_rewritten), .num_bypassed(num_bypassed)
  );

  logic [35:0] sb[$];       // expected {ctrl,data} in output order
  logic [95:0] hq_mac[$];   // lookup entries {dst,src}
  logic        hq_en[$];
  logic [35:0] pkt[$];
  int vectors = 0, miscompares = 0;
  int m_rew = 0, m_byp = 0, exp_rd = 0, rd_count = 0;
  logic hstall = 1'b0;
  logic bp_en = 1'b0;

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Lookup side: presents the head entry, pops it one cycle after hdr_rd.
  initial begin : hdr_side
    logic rd_now;
    forever begin
      @(negedge clk);
      rd_now = hdr_rd;
      @(posedge clk);
      #2;
      if (rd_now === 1'b1) begin
        rd_count++;
        if (hq_mac.size() > 0) begin
          void'(hq_mac.pop_front());
          void'(hq_en.pop_front());
        end
      end
      if (hq_mac.size() > 0 && !hstall) begin
        hdr_vld = 1'b1;
        {hdr_dst_mac, hdr_src_mac} = hq_mac[0];
        hdr_rewrite_en = hq_en[0];
      end else begin
        hdr_vld = 1'b0;
        hdr_dst_mac = 48'({$urandom(), $urandom()});
        hdr_src_mac = 48'({$urandom(), $urandom()});
      end
    end
  end

  initial begin : bp_side
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          out_rdy = ~out_rdy;
        end
      end else begin
        out_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      if (sb.size() == 0) check("unexpected_out", {out_ctrl, out_data}, 36'hx);
      else check("out_word", {out_ctrl, out_data}, sb.pop_front());
    end
  end

  task automatic build(input int nhdr, input int ndata);
    pkt.delete();
    repeat (nhdr) pkt.push_back({4'(CTRL_MOD_HDR), 32'($urandom())});
    for (int i = 0; i < ndata; i++)
      pkt.push_back({(i == ndata - 1) ? 4'(1 << $urandom_range(3, 0)) : 4'h0, 32'($urandom())});
  endtask

  // Reference: leading ctrl!=0 words are module headers; the first three words
  // after them carry bytes 0..11 of the packet, i.e. {dst,src} when rewriting.
  task automatic model(input logic [47:0] dst, input logic [47:0] src, input logic en,
                       input int limit);
    logic [95:0] nh;
    logic [31:0] d;
    logic [3:0]  c;
    int di;
    nh = {dst, src};
    di = 0;
    hq_mac.push_back(nh);
    hq_en.push_back(en);
    for (int i = 0; i < pkt.size() && (limit < 0 || i < limit); i++) begin
      d = pkt[i][31:0];
      c = pkt[i][35:32];
      if (di == 0 && c != 4'h0) begin
        sb.push_back(pkt[i]);
      end else begin
        if (en && di < 3) d = nh[95-32*di -: 32];
        di++;
        sb.push_back({c, d});
      end
    end
    if (en) m_rew++;
    else    m_byp++;
    exp_rd++;
  endtask

  task automatic send_word(input logic [35:0] w);
    int guard;
    logic acc;
    guard = 0;
    {in_ctrl, in_data} = w;
    in_wr = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      if (acc === 1'b1) break;
      guard++;
      if (guard >= 200) begin
        check("accept_timeout", 36'(guard), 36'd0);
        break;
      end
    end
    in_wr = 1'b0;
  endtask

  task automatic send_pkt(input int limit);
    for (int i = 0; i < pkt.size() && (limit < 0 || i < limit); i++) send_word(pkt[i]);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 36'(sb.size()), 36'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_num_rewritten"}, 36'(num_rewritten), 36'(m_rew));
    check({tag, "_num_bypassed"}, 36'(num_bypassed), 36'(m_byp));
    check({tag, "_hdr_rd_pulses"}, 36'(rd_count), 36'(exp_rd));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_data"}, 36'(out_data), 36'd0);
    check({tag, "_out_ctrl"}, 36'(out_ctrl), 36'd0);
    check({tag, "_out_wr"}, 36'(out_wr), 36'd0);
    check({tag, "_hdr_rd"}, 36'(hdr_rd), 36'd0);
    check({tag, "_num_rewritten"}, 36'(num_rewritten), 36'd0);
    check({tag, "_num_bypassed"}, 36'(num_bypassed), 36'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // basic rewrite, then the same packet bypassed
    build(1, 16);
    model(48'h001122334455, 48'hAABBCCDDEEFF, 1'b1, -1);
    send_pkt(-1);
    drain();
    check_counts("basic");
    model(48'h001122334455, 48'hAABBCCDDEEFF, 1'b0, -1);
    send_pkt(-1);
    drain();
    check_counts("bypass");

    // header stall: entry withheld for 10 cycles
    build(0, 16);
    hstall = 1'b1;
    model(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'b1, -1);
    fork
      send_pkt(-1);
      begin
        repeat (10) begin
          @(negedge clk);
          check("stall_in_rdy", 36'(in_rdy), 36'd0);
          check("stall_out_wr", 36'(out_wr), 36'd0);
        end
        @(posedge clk);
        #1;
        hstall = 1'b0;
        @(negedge clk);
        check("release_in_rdy", 36'(in_rdy), 36'd1);
        @(negedge clk);
        check("release_out_wr", 36'(out_wr), 36'd1);
      end
    join
    drain();
    check_counts("stall");

    // backpressure toggling every 3 cycles
    bp_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      build($urandom_range(2, 0), $urandom_range(20, 2));
      model(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'($urandom()), -1);
      send_pkt(-1);
    end
    bp_en = 1'b0;
    drain();
    check_counts("backpressure");

    // runt ending in WORD_2, followed by a normal packet with the next entry
    build(1, 2);
    model(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'b1, -1);
    send_pkt(-1);
    build(1, 8);
    model(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'b1, -1);
    send_pkt(-1);
    drain();
    check_counts("runt");

    // reset while word 3 is presented
    build(1, 16);
    model(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'b1, 3);
    send_pkt(3);
    {in_ctrl, in_data} = pkt[3];
    in_wr = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_rew = 0;
    m_byp = 0;
    check("midreset_sb_empty", 36'(sb.size()), 36'd0);
    build(1, 16);
    model(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'b1, -1);
    send_pkt(-1);
    drain();
    check_counts("after_reset");

    // random traffic
    for (int p = 0; p < 40; p++) begin
      bp_en = 1'($urandom());
      build($urandom_range(2, 0), $urandom_range(20, 2));
      model(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'($urandom()), -1);
      send_pkt(-1);
    end
    bp_en = 1'b0;
    drain();
    check_counts("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
